vc_scheduler: RTL

Weighted round-robin scheduler between the two virtual-channel FIFOs (VC0, VC1) and the two destination FIFOs (D0, D1) of the QoS datapath. Each cycle it pops at most one word from a VC FIFO head, selects the destination from the word's destination bit, and pushes the word into D0 or D1 one cycle later. Destinations at their almost-full threshold are not served. Per-VC weights are latched during an init phase.

---
 rtl/vc_scheduler.sv | 120 ++++++++++++
 1 files changed

// File: rtl/vc_scheduler.sv
// Weighted round-robin scheduler moving words from two VC FIFOs to two destination FIFOs.
// Define VC_SCHED_STRICT_PRIO_EN to replace weighted round-robin with strict VC0-first priority.
module vc_scheduler #(
  parameter int BW       = 6,
  parameter int WEIGHT_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                init,
  input  logic [WEIGHT_W-1:0] vc0_weight,
  input  logic [WEIGHT_W-1:0] vc1_weight,
  input  logic                vc0_empty,
  input  logic                vc1_empty,
  input  logic [BW-1:0]       vc0_data,
  input  logic [BW-1:0]       vc1_data,
  input  logic                d0_almost_full,
  input  logic                d1_almost_full,
  output logic                vc0_pop,
  output logic                vc1_pop,
  output logic                d0_push,
  output logic                d1_push,
  output logic [BW-1:0]       data_out,
  output logic [1:0]          state_out,
  output logic                idle_out,
  output logic                active_out
);

  typedef enum logic [1:0] {
    ST_INIT   = 2'b00,
    ST_IDLE   = 2'b01,
    ST_ACTIVE = 2'b10
  } state_t;

  state_t              state;
  logic [WEIGHT_W-1:0] weight0, weight1;
  logic                elig0, elig1, grant_valid, grant_vc, pop;
  logic [BW-1:0]       grant_data;

`ifndef VC_SCHED_STRICT_PRIO_EN
  logic                cur_vc;
  logic [WEIGHT_W-1:0] credit, next_credit, grant_weight;
`endif

  // A VC is eligible only if its head word's destination can still absorb one more push.
  always_comb begin
`ifdef VC_SCHED_STRICT_PRIO_EN
    elig0    = !vc0_empty && !(vc0_data[BW-2] ? d1_almost_full : d0_almost_full);
    elig1    = !vc1_empty && !(vc1_data[BW-2] ? d1_almost_full : d0_almost_full);
    grant_vc = !elig0;
`else
    elig0    = !vc0_empty && (weight0 != '0) &&
               !(vc0_data[BW-2] ? d1_almost_full : d0_almost_full);
    elig1    = !vc1_empty && (weight1 != '0) &&
               !(vc1_data[BW-2] ? d1_almost_full : d0_almost_full);
    grant_vc = cur_vc ? elig1 : !elig0;
`endif
    grant_valid = elig0 || elig1;
    pop         = (state == ST_ACTIVE) && !init && grant_valid;
    vc0_pop     = pop && !grant_vc;
    vc1_pop     = pop && grant_vc;
    grant_data  = grant_vc ? vc1_data : vc0_data;
  end

`ifndef VC_SCHED_STRICT_PRIO_EN
  always_comb begin
    grant_weight = grant_vc ? weight1 : weight0;
    next_credit  = ((grant_vc == cur_vc) ? credit : '0) + WEIGHT_W'(1);
  end

  // Credit counts consecutive grants within the current VC's turn.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_vc <= 1'b0;
      credit <= '0;
    end else if (pop) begin
      if (next_credit >= grant_weight) begin
        cur_vc <= ~grant_vc;
        credit <= '0;
      end else begin
        cur_vc <= grant_vc;
        credit <= next_credit;
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_INIT;
      weight0  <= '0;
      weight1  <= '0;
      d0_push  <= 1'b0;
      d1_push  <= 1'b0;
      data_out <= '0;
    end else begin
      d0_push <= pop && !grant_data[BW-2];
      d1_push <= pop && grant_data[BW-2];
      if (pop) data_out <= grant_data;
      if (init) begin
        weight0 <= vc0_weight;
        weight1 <= vc1_weight;
      end
      if (init) begin
        state <= ST_INIT;
      end else begin
        unique case (state)
          ST_INIT:   state <= ST_IDLE;
          ST_IDLE:   state <= grant_valid ? ST_ACTIVE : ST_IDLE;
          ST_ACTIVE: state <= grant_valid ? ST_ACTIVE : ST_IDLE;
          default:   state <= ST_INIT;
        endcase
      end
    end
  end

  assign state_out  = state;
  assign idle_out   = (state == ST_IDLE);
  assign active_out = (state == ST_ACTIVE);

endmodule
